// File: rtl/counter_sched.sv
// counter_sched: round-robin scheduler that lends one shared up-counter to
// NREQ requesters, each asking for a one-shot delay of a programmable length.
// The owner keeps gnt while the counter runs from 0 up to its delay value.
// The owner then gets a single-cycle done pulse, and the block returns to
// IDLE for at least one cycle before the next grant.
module counter_sched #(
  parameter int NREQ = 4,
  parameter int N    = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] delay,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [N-1:0]      count
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [IW-1:0] owner;
  logic [IW-1:0] last;
  logic [IW-1:0] win;
  logic [IW-1:0] cand;
  logic          found;
  logic [N-1:0]  target;

  // Round-robin search: the first requester after the last winner, wrapping modulo NREQ.
  always_comb begin
    win   = last;
    cand  = last;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last) + k) % NREQ);
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  // Scheduler FSM. Outputs are registered, and the delay is latched only at grant time.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      gnt    <= '0;
      done   <= '0;
      count  <= '0;
      owner  <= '0;
      target <= '0;
      last   <= IW'(NREQ - 1);
    end else begin
      case (state)
        IDLE: begin
          done  <= '0;
          count <= '0;
          if (|req) begin
            state  <= RUN;
            gnt    <= ONE_HOT0 << win;
            owner  <= win;
            last   <= win;
            target <= delay[win*N +: N];
          end else begin
            gnt <= '0;
          end
        end
        RUN: begin
          if (!req[owner]) begin
            // The owner withdrew, so give the counter back without a done pulse.
            state <= IDLE;
            gnt   <= '0;
            count <= '0;
          end else if (count == target) begin
            // Hold count at target. The counter therefore never wraps, even for delay = 2^N-1.
            state <= DONE;
            done  <= ONE_HOT0 << owner;
          end else begin
            count <= count + N'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          gnt   <= '0;
          done  <= '0;
          count <= '0;
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          done  <= '0;
          count <= '0;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_counter_sched.sv
// Testbench for counter_sched. Each scenario queues the expected per-cycle
// {gnt, done, count, busy} timeline as it drives stimulus. It then pops one
// entry after every rising edge and compares it with the DUT.
// A second instance with N=4 covers the maximum-delay boundary.
module tb_counter_sched;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [79:0] delay;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        busy;
  logic [19:0] count;

  logic [1:0]  req4;
  logic [7:0]  delay4;
  logic [1:0]  gnt4;
  logic [1:0]  done4;
  logic        busy4;
  logic [3:0]  count4;

  typedef struct packed {
    logic [3:0]  g;
    logic [3:0]  d;
    logic [19:0] c;
    logic        b;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_checks;
  int   n_fail;

  counter_sched #(.NREQ(4), .N(20)) u_dut (
    .clk(clk), .rst(rst), .req(req), .delay(delay),
    .gnt(gnt), .done(done), .busy(busy), .count(count)
  );

  counter_sched #(.NREQ(2), .N(4)) u_dut4 (
    .clk(clk), .rst(rst), .req(req4), .delay(delay4),
    .gnt(gnt4), .done(done4), .busy(busy4), .count(count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected timeline of one complete grant with delay d:
  // RUN cycles counting 0..d, then one DONE cycle with count held at d.
  function automatic void push_slot(input logic [3:0] g, input int d);
    for (int k = 0; k <= d; k++) q.push_back({g, 4'b0000, 20'(k), 1'b1});
    q.push_back({g, g, 20'(d), 1'b1});
  endfunction

  function automatic void push_idle();
    q.push_back({4'b0000, 4'b0000, 20'd0, 1'b0});
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({gnt, done, count, busy} !== 29'd0) begin
      n_fail++;
      $display("FAIL reset_main: got gnt=%b done=%b count=%0d busy=%b, want all zero", gnt, done, count, busy);
    end
    n_checks++;
    if ({gnt4, done4, count4, busy4} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_n4: got gnt=%b done=%b count=%0d busy=%b, want all zero", gnt4, done4, count4, busy4);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int step;
    step = 0;
    delay[0 +: 20] = 20'd5;
    req = 4'b0001;
    push_slot(4'b0001, 5);
    push_idle();
    push_idle();
    while (q.size() > 0) begin
      @(posedge clk); #1;
      e = q.pop_front();
      n_checks++;
      if ({gnt, done, count, busy} !== e) begin
        n_fail++;
        $display("FAIL single step %0d: got gnt=%b done=%b count=%0d busy=%b, want gnt=%b done=%b count=%0d busy=%b",
                 step, gnt, done, count, busy, e.g, e.d, e.c, e.b);
      end
      // Changing the delay after the grant must have no effect.
      if (step == 0) delay[0 +: 20] = 20'd9;
      if (e.d != 4'b0000) begin
        req = req & ~e.d;
        $display("txn single: done=%b at step %0d", e.d, step);
      end
      step++;
    end
  endtask

  task automatic test_zero_delay();
    int step;
    step = 0;
    delay[40 +: 20] = 20'd0;
    req = 4'b0100;
    push_slot(4'b0100, 0);
    push_idle();
    while (q.size() > 0) begin
      @(posedge clk); #1;
      e = q.pop_front();
      n_checks++;
      if ({gnt, done, count, busy} !== e) begin
        n_fail++;
        $display("FAIL zero_delay step %0d: got gnt=%b done=%b count=%0d busy=%b, want gnt=%b done=%b count=%0d busy=%b",
                 step, gnt, done, count, busy, e.g, e.d, e.c, e.b);
      end
      if (e.d != 4'b0000) begin
        req = req & ~e.d;
        $display("txn zero_delay: done=%b at step %0d", e.d, step);
      end
      step++;
    end
  endtask

  task automatic test_round_robin();
    int step;
    int ndone;
    int order[6];
    order = '{0, 1, 2, 3, 0, 1};
    step = 0;
    ndone = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    delay = {4{20'd2}};
    req = 4'b1111;
    foreach (order[i]) begin
      push_slot(4'(1 << order[i]), 2);
      push_idle();
    end
    push_idle();
    while (q.size() > 0) begin
      @(posedge clk); #1;
      e = q.pop_front();
      n_checks++;
      if ({gnt, done, count, busy} !== e) begin
        n_fail++;
        $display("FAIL round_robin step %0d: got gnt=%b done=%b count=%0d busy=%b, want gnt=%b done=%b count=%0d busy=%b",
                 step, gnt, done, count, busy, e.g, e.d, e.c, e.b);
      end
      if (e.d != 4'b0000) begin
        ndone++;
        $display("txn round_robin: done=%b (grant %0d)", e.d, ndone);
        if (ndone == 6) req = 4'b0000;
      end
      step++;
    end
  endtask

  task automatic test_abort();
    int step;
    step = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    delay[20 +: 20] = 20'd10;
    delay[60 +: 20] = 20'd1;
    req = 4'b1010;
    for (int k = 0; k <= 3; k++) q.push_back({4'b0010, 4'b0000, 20'(k), 1'b1});
    push_idle();
    push_slot(4'b1000, 1);
    push_idle();
    while (q.size() > 0) begin
      @(posedge clk); #1;
      e = q.pop_front();
      n_checks++;
      if ({gnt, done, count, busy} !== e) begin
        n_fail++;
        $display("FAIL abort step %0d: got gnt=%b done=%b count=%0d busy=%b, want gnt=%b done=%b count=%0d busy=%b",
                 step, gnt, done, count, busy, e.g, e.d, e.c, e.b);
      end
      if (step == 3) begin
        req[1] = 1'b0;
        $display("txn abort: requester 1 withdrew at count 3");
      end
      if (e.d != 4'b0000) begin
        req = req & ~e.d;
        $display("txn abort: done=%b at step %0d", e.d, step);
      end
      step++;
    end
  endtask

  task automatic test_reset_mid();
    int step;
    step = 0;
    delay[0 +: 20] = 20'd10;
    delay[40 +: 20] = 20'd0;
    req = 4'b0101;
    for (int k = 0; k <= 7; k++) q.push_back({4'b0001, 4'b0000, 20'(k), 1'b1});
    while (q.size() > 0) begin
      @(posedge clk); #1;
      e = q.pop_front();
      n_checks++;
      if ({gnt, done, count, busy} !== e) begin
        n_fail++;
        $display("FAIL reset_mid_run step %0d: got gnt=%b done=%b count=%0d busy=%b, want gnt=%b done=%b count=%0d busy=%b",
                 step, gnt, done, count, busy, e.g, e.d, e.c, e.b);
      end
      step++;
    end
    rst = 1'b1;
    delay[0 +: 20] = 20'd1;
    @(posedge clk); #1;
    n_checks++;
    if ({gnt, done, count, busy} !== 29'd0) begin
      n_fail++;
      $display("FAIL reset_mid_clear: got gnt=%b done=%b count=%0d busy=%b, want all zero", gnt, done, count, busy);
    end
    rst = 1'b0;
    $display("txn reset_mid: reset applied at count 7");
    push_slot(4'b0001, 1);
    push_idle();
    push_slot(4'b0100, 0);
    push_idle();
    step = 0;
    while (q.size() > 0) begin
      @(posedge clk); #1;
      e = q.pop_front();
      n_checks++;
      if ({gnt, done, count, busy} !== e) begin
        n_fail++;
        $display("FAIL reset_mid_after step %0d: got gnt=%b done=%b count=%0d busy=%b, want gnt=%b done=%b count=%0d busy=%b",
                 step, gnt, done, count, busy, e.g, e.d, e.c, e.b);
      end
      if (e.d != 4'b0000) begin
        req = req & ~e.d;
        $display("txn reset_mid: done=%b at step %0d", e.d, step);
      end
      step++;
    end
  endtask

  task automatic test_width();
    int step;
    step = 0;
    delay4[3:0] = 4'd15;
    req4 = 2'b01;
    push_slot(4'b0001, 15);
    push_idle();
    while (q.size() > 0) begin
      @(posedge clk); #1;
      e = q.pop_front();
      n_checks++;
      if ({2'b00, gnt4, 2'b00, done4, 16'd0, count4, busy4} !== e) begin
        n_fail++;
        $display("FAIL width_n4 step %0d: got gnt=%b done=%b count=%0d busy=%b, want gnt=%b done=%b count=%0d busy=%b",
                 step, gnt4, done4, count4, busy4, e.g, e.d, e.c, e.b);
      end
      if (e.d != 4'b0000) begin
        req4 = req4 & ~e.d[1:0];
        $display("txn width: done=%b at step %0d", e.d, step);
      end
      step++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    req      = '0;
    delay    = '0;
    req4     = '0;
    delay4   = '0;
    test_reset();
    test_single();
    test_zero_delay();
    test_round_robin();
    test_abort();
    test_reset_mid();
    test_width();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
